instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Producer side of the decoder's Op/Funct interface: owns the PC, fetches 32-bit words from instruction memory, and buffers them in a small FIFO.
- Presents each instruction with its Op/Funct fields to the control unit over a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage; a redirect flushes in-flight and buffered instructions.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 0, first fetch address after reset; must be word-aligned.
- DEPTH, 2, instruction FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch word address; bits [1:0] always 0.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response data valid; arrives at least 1 cycle after request acceptance.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  branch/jump taken; 1-cycle pulse.
- redirect_pc  in  ADDR_W  target address; bits [1:0] ignored and forced to 0.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  head instruction; 0 when empty.
- out_pc  out  ADDR_W  address of the head instruction; 0 when empty.
- out_op  out  6  out_instr[31:26].
- out_funct  out  6  out_instr[5:0].

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - fetch_pc=RESET_PC, FIFO count=0, state=REQ.
  - imem_req_valid=0 while rst_n=0.
  - out_valid=0; out_instr, out_pc, out_op, out_funct = 0.
  - Any outstanding request is forgotten; a response arriving after reset is ignored.
- At most one outstanding memory request.
- FSM states:
  - REQ: imem_req_valid=1 iff count<DEPTH; imem_req_addr=fetch_pc. On handshake (valid & ready): req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0), go to WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid: push {imem_rsp_data, req_pc} into the FIFO, go to REQ.
  - DROP: imem_req_valid=0. On imem_rsp_valid: discard the data, go to REQ.
- Space reservation: a request is issued only when count<DEPTH, so a response push can never overflow. A pop in the same cycle as a push leaves count unchanged.
- Output side:
  - out_valid = (count != 0).
  - out_* are driven combinationally from the FIFO head.
  - A pop occurs on out_valid & out_ready.
  - The head is stable while out_valid=1 and out_ready=0.
- Latency:
  - Request acceptance at cycle N with response at N+1 → push at N+1, out_valid=1 at N+2.
  - Next request is issued at N+2.
  - Sustained throughput is 1 instruction per 2 cycles with zero-wait memory.
- Redirect (highest priority; overrides pop, push, and PC increment in the same cycle):
  - FIFO count<=0; fetch_pc<={redirect_pc[ADDR_W-1:2],2'b00}.
  - From REQ without a handshake: stay in REQ; the next request uses the new PC.
  - From REQ with a handshake in the same cycle: that request is outstanding → go to DROP.
  - From WAIT without rsp_valid: go to DROP.
  - From WAIT with rsp_valid in the same cycle: the response is discarded → go to REQ.
  - From DROP: update fetch_pc, stay in DROP (or go to REQ if rsp_valid arrives that cycle, discarding it).
- An instruction popped in the same cycle as a redirect counts as consumed by the consumer; the unit does not re-present it.
- FIFO full: imem_req_valid=0 until a pop.
- FIFO empty: out_valid=0, out_* = 0.
- imem_req_addr is stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs; a redirect may change the address while valid is held.

Test Plan:
- Reset then zero-wait memory returning 0x00851020 (R-type add) at 0x0, 0x8C880004 (lw) at 0x4, with out_ready=1 → out_pc 0x0 with out_op=0, out_funct=0x20; then out_pc 0x4 with out_op=0x23; requests spaced 2 cycles apart.
- out_ready=0 with 3 instructions available → exactly 2 accepted requests (0x0, 0x4), imem_req_valid=0 afterwards, head stays 0x0; raise out_ready → the 0x8 request issues the cycle after the first pop.
- Request at 0x8 accepted with 3-cycle response latency; redirect_valid with redirect_pc=0x43 one cycle after acceptance → FIFO flushed, old response discarded, next request addr=0x40, first out_pc=0x40.
- Redirect in the same cycle as a request handshake at 0x10 → state DROP, response for 0x10 never appears on out_*, next request is to the target.
- Redirect in the same cycle as out_valid&out_ready with count=2 → count=0 next cycle, out_valid=0.
- fetch_pc=0xFFFFFFFC fetched → next request addr=0x00000000; rst_n=0 asserted mid-WAIT, response arrives during reset → out_valid stays 0, first request after reset is to RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. It owns the fetch PC, issues one word fetch at a
// time to instruction memory, buffers the returned words in a small FIFO, and
// presents the head instruction with its Op/Funct fields to the control unit
// over a valid/ready handshake. A redirect from execute flushes the FIFO and
// restarts fetching at the target; a response still in flight at that moment
// is consumed and dropped.
//
// Parameters:
//   ADDR_W   - PC / memory address width
//   RESET_PC - first fetch address after reset (word aligned)
//   DEPTH    - FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   imem_req_valid/_addr/_ready - fetch request channel (word address)
//   imem_rsp_valid/_data        - fetch response channel
//   redirect_valid/_pc          - branch/jump redirect (1-cycle pulse)
//   out_valid/_ready            - handshake toward the control unit
//   out_instr/_pc/_op/_funct    - head instruction, zero while empty
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction memory request
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  // instruction memory response
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  // redirect from execute
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  // decoder-facing output
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [5:0]        out_op,
  output logic [5:0]        out_funct
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ,   // ready to issue the next fetch
    S_WAIT,  // fetch outstanding, response will be buffered
    S_DROP   // fetch outstanding, response will be discarded
  } state_e;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  entry_t            fifo_q [DEPTH];

  logic              req_fire;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_target;
  entry_t            head;
  logic              unused_redirect_lsbs;

  // The target's byte offset is meaningless for word fetches.
  assign redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A request is only offered when a FIFO slot is guaranteed for its response,
  // so a push can never overflow. Gating with rst_n keeps the request low for
  // the whole reset window, including the first edge.
  assign imem_req_valid = rst_n && (state_q == S_REQ) && (count_q < FULL_CNT);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Redirect wins over everything: no push or pop is applied in its cycle.
  // A pop coinciding with a redirect still counts as consumed downstream.
  assign push = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_target;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      // Whatever is in flight must be swallowed before fetching resumes.
      unique case (state_q)
        S_REQ:          state_q <= req_fire ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_q <= imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_q <= S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
            state_q    <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rsp_valid) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{instr: imem_rsp_data, pc: req_pc_q};
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_op    = out_instr[31:26];
  assign out_funct = out_instr[5:0];

endmodule
